// File: rtl/subtract_arbiter.sv
// subtract_arbiter: two requesters share one 4-bit subtract slice.
// A granted operand pair is processed one nibble per cycle, LSB nibble first.
// The result is then held until the consumer takes it.
module subtract_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_diff,
  output logic             rsp_borrow,
  input  logic             rsp_ready
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB + 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_width_check
    $error("subtract_arbiter: WIDTH must be a multiple of 4 in 4..32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_id;
  logic             r_valid;
  logic             r_borrow;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_idle;
  logic [4:0]       w_sum;

  // Round-robin grant: a lone requester always wins; on contention the one not served last wins
  always_comb begin
    w_grant0 = req0_valid && (!req1_valid || r_last);
    w_grant1 = req1_valid && !w_grant0;
    w_idle   = (r_state == S_IDLE) && !rst;
  end

  assign req0_ready = w_idle && w_grant0;
  assign req1_ready = w_idle && w_grant1;

  // Shared 4-bit slice: a + ~b + carry-in on the current low nibble
  always_comb begin
    w_sum = {1'b0, r_a[3:0]} + {1'b0, ~r_b[3:0]} + {4'b0000, r_carry};
  end

  // Operands shift right one nibble per cycle; each sum nibble enters the
  // result at the top, so after NIB cycles every nibble is in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b1;
      r_last   <= 1'b1;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_id     <= 1'b0;
      r_valid  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_a     <= w_grant1 ? req1_a : req0_a;
            r_b     <= w_grant1 ? req1_b : req0_b;
            r_id    <= w_grant1;
            r_last  <= w_grant1;
            r_cnt   <= '0;
            r_carry <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_diff  <= (r_diff >> 4) | (WIDTH'(w_sum[3:0]) << (WIDTH - 4));
          r_carry <= w_sum[4];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NIB - 1)) begin
            r_borrow <= ~w_sum[4];
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = r_valid;
  assign rsp_id     = r_id;
  assign rsp_diff   = r_diff;
  assign rsp_borrow = r_borrow;

endmodule

// File: doc/subtract_arbiter.md
SUBTRACT_ARBITER -- requirements
Module: subtract_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 (legal range 4..32).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 minuend, subtrahend.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready: same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_id  output  1  requester that owns the result (0 or 1).
REQ-010 rsp_diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 rsp_borrow  output  1  1 when a < b (unsigned), i.e. inverted final carry.
REQ-012 rsp_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 Block SHALL share one 4-bit subtract slice (a + ~b + carry-in) between two requesters, processing one nibble per cycle, LSB nibble first.
REQ-014 FSM states SHALL be IDLE, EXEC, DONE; no other states are reachable.
REQ-015 IDLE: if any reqN_valid, grant one requester; assert that requester's reqN_ready combinationally in the same cycle; the other ready SHALL stay 0.
REQ-016 Transfer occurs on reqN_valid && reqN_ready; operands and id SHALL be latched; next state EXEC, nibble counter = 0, carry = 1.
REQ-017 Arbitration SHALL be round-robin: if both valid, grant the requester not served last; if one valid, grant it regardless of history.
REQ-018 Last-served pointer SHALL reset to 1 so requester 0 wins the first contested grant.
REQ-019 EXEC: each cycle compute nibble k = a[k] + ~b[k] + carry, store sum into diff nibble k, carry <= slice carry-out; counter increments.
REQ-020 EXEC SHALL last exactly WIDTH/4 cycles; after the last nibble go to DONE.
REQ-021 rsp_borrow SHALL equal NOT(final carry-out).
REQ-022 Latency: accept at cycle T -> rsp_valid first high at T + 1 + WIDTH/4 (T+5 for WIDTH=16).
REQ-023 DONE: rsp_valid = 1; rsp_id, rsp_diff, rsp_borrow SHALL hold stable until rsp_valid && rsp_ready.
REQ-024 On rsp_ready in DONE, next state IDLE; no new request SHALL be accepted in DONE or EXEC (both readies 0).
REQ-025 Back-to-back throughput: one result per 2 + WIDTH/4 cycles when rsp_ready is held high.
REQ-026 Operand changes on req inputs after acceptance SHALL NOT affect the in-flight result.
REQ-027 Wrap-around: result is modulo 2^WIDTH; no overflow flag is produced.
REQ-028 rsp_valid, reqN_ready SHALL be 0 outside the states stated above.

Reset
REQ-029 rst high at a clock edge SHALL force: state IDLE, counter 0, carry 1, last-served 1, rsp_valid 0, rsp_id 0, rsp_diff 0, rsp_borrow 0.
REQ-030 While rst is high, req0_ready and req1_ready SHALL be 0.
REQ-031 Reset in EXEC or DONE SHALL discard the in-flight operation; no rsp_valid pulse follows it.

Verification
REQ-032 req0 a=0x1234, b=0x0234 -> req0_ready same cycle; rsp_valid 5 cycles later, rsp_id=0, diff=0x1000, borrow=0.
REQ-033 req1 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1; a=b=0xA5A5 -> diff=0x0000, borrow=0.
REQ-034 Both valid continuously, rsp_ready=1 -> grants 0,1,0,1...; each result 6 cycles apart with matching rsp_id.
REQ-035 rsp_ready held 0 for 10 cycles in DONE -> outputs stable, both readies 0, pending req1_valid not accepted until after release.
REQ-036 rst asserted on 2nd EXEC cycle -> next cycle all outputs at reset values, no rsp_valid; subsequent request completes correctly.
REQ-037 Random operands, 1000 transactions, random valid/ready -> every result equals reference (a-b) mod 2^16, borrow = (a<b), no lost or duplicated requests.
